dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_if.sv | 22 ++
 rtl/dmem_ctrl.sv | 128 ++++++++++++
 tb/tb_dmem_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// External data-bus bundle between dmem_ctrl (master) and the memory system (slave).
// Single outstanding request/grant with a separate read-data return.
interface dmem_ctrl_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: in-order store buffer drained onto a request/grant bus,
// loads issued only once all older stores have left the buffer.
module dmem_ctrl #(
    parameter int SB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    input  logic [3:0]  st_byte_i,
    output logic        st_ready_o,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_addr_i,
    output logic [31:0] dmem_read_data_o,
    output logic        dmem_read_valid_o,
    output logic        sb_empty_o,
    dmem_ctrl_if.master bus
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT, LD_DONE} state_t;

    state_t         state, state_nxt;
    logic [29:0]    sb_addr [SB_DEPTH];
    logic [31:0]    sb_data [SB_DEPTH];
    logic [3:0]     sb_be   [SB_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_nxt;
    logic [29:0]    ld_addr_q;
    logic           enq, deq;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^{st_addr_i[1:0], ld_addr_i[1:0]};

    assign st_ready_o = (count != CW'(SB_DEPTH));
    assign sb_empty_o = (count == '0);
    assign enq        = st_valid_i && st_ready_o && (st_byte_i != 4'h0);
    assign deq        = (state == ST_REQ) && bus.bus_gnt_i;

    always_comb begin
        count_nxt = count;
        if (enq && !deq)
            count_nxt = count + CW'(1);
        else if (!enq && deq)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // A store being pushed this cycle is older than a load seen this cycle,
            // so it holds the load off until the buffer has drained.
            IDLE: begin
                if (count != '0)
                    state_nxt = ST_REQ;
                else if (ld_valid_i && !enq)
                    state_nxt = LD_REQ;
            end
            ST_REQ:  if (bus.bus_gnt_i && count_nxt == '0) state_nxt = IDLE;
            LD_REQ:  if (bus.bus_gnt_i) state_nxt = LD_WAIT;
            LD_WAIT: if (bus.bus_rvalid_i) state_nxt = LD_DONE;
            LD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_req_o     = 1'b0;
        bus.bus_we_o      = 1'b0;
        bus.bus_addr_o    = '0;
        bus.bus_wdata_o   = '0;
        bus.bus_be_o      = '0;
        dmem_read_valid_o = 1'b0;
        case (state)
            ST_REQ: begin
                bus.bus_req_o   = 1'b1;
                bus.bus_we_o    = 1'b1;
                bus.bus_addr_o  = {sb_addr[rd_ptr], 2'b00};
                bus.bus_wdata_o = sb_data[rd_ptr];
                bus.bus_be_o    = sb_be[rd_ptr];
            end
            LD_REQ: begin
                bus.bus_req_o  = 1'b1;
                bus.bus_addr_o = {ld_addr_q, 2'b00};
                bus.bus_be_o   = 4'hF;
            end
            LD_DONE: dmem_read_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            ld_addr_q        <= '0;
            dmem_read_data_o <= '0;
        end else begin
            count <= count_nxt;
            if (enq)
                wr_ptr <= wr_ptr + PW'(1);
            if (deq)
                rd_ptr <= rd_ptr + PW'(1);
            if (state == IDLE && state_nxt == LD_REQ)
                ld_addr_q <= ld_addr_i[31:2];
            if (state == LD_WAIT && bus.bus_rvalid_i)
                dmem_read_data_o <= bus.bus_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            sb_addr[wr_ptr] <= st_addr_i[31:2];
            sb_data[wr_ptr] <= st_data_i;
            sb_be[wr_ptr]   <= st_byte_i;
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a bus monitor compares every granted request and
// every load-complete pulse against a scoreboard filled when stimulus is driven.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr, st_data;
    logic [3:0]  st_byte;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        sb_empty;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] last_rd = '0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    typedef struct {
        bit          is_ld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_addr;
    } vec_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    vec_t        vecs[7];

    dmem_ctrl_if bus ();

    dmem_ctrl #(.SB_DEPTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .st_valid_i        (st_valid),
        .st_addr_i         (st_addr),
        .st_data_i         (st_data),
        .st_byte_i         (st_byte),
        .st_ready_o        (st_ready),
        .ld_valid_i        (ld_valid),
        .ld_addr_i         (ld_addr),
        .dmem_read_data_o  (rd_data),
        .dmem_read_valid_o (rd_valid),
        .sb_empty_o        (sb_empty),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bus_t got, e;
        if (!reset) begin
            if (bus.bus_req_o && bus.bus_gnt_i) begin
                got = '{bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_be_o};
                compared++;
                if (exp_bus.size() == 0) begin
                    mismatched++;
                    $display("FAIL bus_txn: unexpected we=%0b addr=%h", got.we, got.addr);
                end else begin
                    e = exp_bus.pop_front();
                    if (got !== e) begin
                        mismatched++;
                        $display("FAIL bus_txn: got %h expected %h", got, e);
                    end
                end
            end
            if (rd_valid) begin
                compared++;
                if (exp_rd.size() == 0) begin
                    mismatched++;
                    $display("FAIL rd_pulse: unexpected pulse data=%h", rd_data);
                end else begin
                    logic [31:0] ed;
                    ed = exp_rd.pop_front();
                    if (rd_data !== ed) begin
                        mismatched++;
                        $display("FAIL rd_data: got %h expected %h", rd_data, ed);
                    end
                end
            end
        end
    end

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bit acc = 0;
        st_valid = 1'b1; st_addr = a; st_data = d; st_byte = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            logic rdy;
            @(negedge clk); rdy = st_ready;
            @(posedge clk); #1;
            acc = rdy;
        end
        st_valid = 1'b0;
        if (!acc) begin
            compared++; mismatched++;
            $display("FAIL store_accept_timeout: got 0 expected 1");
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] ea, input logic [31:0] d);
        bit seen = 0;
        exp_bus.push_back('{1'b0, ea, 32'h0, 4'hF});
        exp_rd.push_back(d);
        ld_valid = 1'b1; ld_addr = a;
        @(posedge clk); #1;
        st_valid = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.bus_req_o && !bus.bus_we_o;
        end
        if (!seen) begin
            compared++; mismatched++;
            $display("FAIL load_req_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = d;
        @(posedge clk); #1;
        bus.bus_rvalid_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        last_rd = d;
    endtask

    task automatic wait_empty();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = sb_empty && !bus.bus_req_o;
        end
        chk("drain_timeout", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{0, 32'h0000_0010, 32'h1111_1111, 4'hF,    32'h0000_0010};
        vecs[1] = '{0, 32'h0000_0021, 32'h2222_2222, 4'b0011, 32'h0000_0020};
        vecs[2] = '{0, 32'h0000_0033, 32'h3333_3333, 4'h0,    32'h0000_0030};
        vecs[3] = '{0, 32'h8000_0046, 32'h4444_4444, 4'b0100, 32'h8000_0044};
        vecs[4] = '{1, 32'h0000_5006, 32'hCAFE_F00D, 4'hF,    32'h0000_5004};
        vecs[5] = '{0, 32'hFFFF_FFFF, 32'h5555_5555, 4'b1000, 32'hFFFF_FFFC};
        vecs[6] = '{0, 32'h0000_0104, 32'h6666_6666, 4'b0001, 32'h0000_0104};

        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_byte = '0;
        ld_valid = 1'b0; ld_addr = '0;
        bus.bus_gnt_i = 1'b1; bus.bus_rvalid_i = 1'b0; bus.bus_rdata_i = '0;

        @(negedge clk);
        chk("rst_req", bus.bus_req_o, 0);
        chk("rst_addr", bus.bus_addr_o, 0);
        chk("rst_be", bus.bus_be_o, 0);
        chk("rst_ready", st_ready, 1);
        chk("rst_empty", sb_empty, 1);
        chk("rst_rdata", rd_data, 0);
        chk("rst_rvalid", rd_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single store: bus write in cycle 2
        exp_bus.push_back('{1'b1, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000});
        st_valid = 1'b1; st_addr = 32'h0000_1003; st_data = 32'hABAB_ABAB; st_byte = 4'b1000;
        @(negedge clk); chk("st_c0_req", bus.bus_req_o, 0);
        @(posedge clk); #1; st_valid = 1'b0;
        @(negedge clk); chk("st_c1_req", bus.bus_req_o, 0);
        @(negedge clk);
        chk("st_c2_req", bus.bus_req_o, 1);
        chk("st_c2_we", bus.bus_we_o, 1);
        chk("st_c2_addr", bus.bus_addr_o, 32'h0000_1000);
        chk("st_c2_be", bus.bus_be_o, 4'b1000);
        @(negedge clk);
        chk("st_c3_empty", sb_empty, 1);
        chk("st_c3_req", bus.bus_req_o, 0);
        @(posedge clk); #1;

        // table-driven stream under continuous grant
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_ld) begin
                do_load(vecs[i].addr, vecs[i].exp_addr, vecs[i].data);
            end else begin
                if (vecs[i].be != 4'h0)
                    exp_bus.push_back('{1'b1, vecs[i].exp_addr, vecs[i].data, vecs[i].be});
                push_store(vecs[i].addr, vecs[i].data, vecs[i].be);
            end
        end
        wait_empty();

        // full buffer: third store stalls until a slot frees
        bus.bus_gnt_i = 1'b0;
        exp_bus.push_back('{1'b1, 32'h0000_0100, 32'h0000_00A1, 4'hF});
        exp_bus.push_back('{1'b1, 32'h0000_0204, 32'h0000_00B2, 4'b0011});
        exp_bus.push_back('{1'b1, 32'h0000_0308, 32'h0000_00C3, 4'b1100});
        st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hA1; st_byte = 4'hF;
        @(posedge clk); #1; st_addr = 32'h204; st_data = 32'hB2; st_byte = 4'b0011;
        @(posedge clk); #1; st_addr = 32'h30A; st_data = 32'hC3; st_byte = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_ready", st_ready, 0);
            chk("full_hold_addr", bus.bus_addr_o, 32'h0000_0100);
            chk("full_hold_req", bus.bus_req_o, 1);
        end
        @(posedge clk); #1; bus.bus_gnt_i = 1'b1;
        @(negedge clk); chk("full_w0_addr", bus.bus_addr_o, 32'h0000_0100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_w1_addr", bus.bus_addr_o, 32'h0000_0204);
        chk("full_w1_ready", st_ready, 1);
        @(posedge clk); #1; st_valid = 1'b0;
        @(negedge clk); chk("full_w2_addr", bus.bus_addr_o, 32'h0000_0308);
        @(negedge clk);
        chk("full_end_req", bus.bus_req_o, 0);
        chk("full_end_empty", sb_empty, 1);
        @(posedge clk); #1;

        // load ordering: store and load presented together, write goes first
        exp_bus.push_back('{1'b1, 32'h0000_2000, 32'h5A5A_5A5A, 4'hF});
        st_valid = 1'b1; st_addr = 32'h2000; st_data = 32'h5A5A_5A5A; st_byte = 4'hF;
        do_load(32'h0000_2004, 32'h0000_2004, 32'hDEAD_BEEF);
        chk("ord_rdata_hold", rd_data, 32'hDEAD_BEEF);
        wait_empty();

        // minimum load latency, ld_valid held through LD_DONE
        exp_bus.push_back('{1'b0, 32'h0000_3000, 32'h0, 4'hF});
        exp_rd.push_back(32'h1357_9BDF);
        ld_valid = 1'b1; ld_addr = 32'h0000_3002;
        @(negedge clk); chk("ld_c0_req", bus.bus_req_o, 0);
        @(negedge clk);
        chk("ld_c1_req", bus.bus_req_o, 1);
        chk("ld_c1_we", bus.bus_we_o, 0);
        chk("ld_c1_addr", bus.bus_addr_o, 32'h0000_3000);
        chk("ld_c1_be", bus.bus_be_o, 4'hF);
        @(posedge clk); #1; bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 32'h1357_9BDF;
        @(negedge clk); chk("ld_c2_valid", rd_valid, 0);
        @(posedge clk); #1; bus.bus_rvalid_i = 1'b0;
        @(negedge clk); chk("ld_c3_valid", rd_valid, 1);
        @(posedge clk); #1; ld_valid = 1'b0;
        @(negedge clk);
        chk("ld_c4_req", bus.bus_req_o, 0);
        chk("ld_c4_valid", rd_valid, 0);
        last_rd = 32'h1357_9BDF;
        @(posedge clk); #1;

        // zero byte enables and stray rvalid in IDLE
        st_valid = 1'b1; st_addr = 32'h7000; st_data = 32'h99; st_byte = 4'h0;
        bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk); chk("zbe_ready", st_ready, 1);
        @(posedge clk); #1; st_valid = 1'b0; bus.bus_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zbe_req", bus.bus_req_o, 0);
            chk("zbe_empty", sb_empty, 1);
            chk("zbe_rdata", rd_data, last_rd);
        end
        @(posedge clk); #1;

        // reset in LD_WAIT with a buffered store and a late rvalid
        bus.bus_gnt_i = 1'b0;
        exp_bus.push_back('{1'b0, 32'h0000_4008, 32'h0, 4'hF});
        ld_valid = 1'b1; ld_addr = 32'h0000_4008;
        repeat (2) @(posedge clk);
        #1; bus.bus_gnt_i = 1'b1;
        @(posedge clk); #1; bus.bus_gnt_i = 1'b0;
        st_valid = 1'b1; st_addr = 32'h6000; st_data = 32'h66; st_byte = 4'hF;
        @(posedge clk); #1; st_valid = 1'b0;
        chk("rst2_pre_empty", sb_empty, 0);
        #2; reset = 1'b1; ld_valid = 1'b0;
        #1;
        chk("rst2_req", bus.bus_req_o, 0);
        chk("rst2_we", bus.bus_we_o, 0);
        chk("rst2_wdata", bus.bus_wdata_o, 0);
        chk("rst2_ready", st_ready, 1);
        chk("rst2_empty", sb_empty, 1);
        chk("rst2_rdata", rd_data, 0);
        @(posedge clk); #1;
        reset = 1'b0; bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 32'h7777_7777;
        @(posedge clk); #1; bus.bus_rvalid_i = 1'b0; bus.bus_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst2_post_req", bus.bus_req_o, 0);
            chk("rst2_post_valid", rd_valid, 0);
            chk("rst2_post_rdata", rd_data, 0);
        end

        chk("sb_bus_left", exp_bus.size(), 0);
        chk("sb_rd_left", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
